memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 25 ++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// RAM state encoding and the core/RAM bus bundle seen by memory_arbiter.
// master = arbiter side, slave = cores plus RAM.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

interface memory_arbiter_if #(parameter int CPUS = 2);
    import cpu_types_pkg::*;
    logic [CPUS-1:0]        iREN, dREN, dWEN;
    logic [CPUS-1:0][31:0]  iaddr, daddr, dstore;
    logic [CPUS-1:0]        iwait, dwait;
    logic [CPUS-1:0][31:0]  iload, dload;
    logic                   ramREN, ramWEN;
    logic [31:0]            ramaddr, ramstore, ramload;
    ramstate_t              ramstate;

    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-core round-robin arbiter for a single shared RAM (ARB/GRANT FSM).
// Define ARB_TIMEOUT_EN to abandon a grant after TMO cycles without ACCESS.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int TMO  = 255
) (
    input  logic                CLK,
    input  logic                nRST,
    memory_arbiter_if.master    bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                tmo_err
`endif
);

    if (CPUS != 2) begin : g_cpus_chk
        $error("memory_arbiter supports CPUS=2 only");
    end
    if (TMO < 1) begin : g_tmo_chk
        $error("memory_arbiter needs TMO >= 1");
    end

    typedef enum logic {ARB = 1'b0, GRANT = 1'b1} state_t;

    state_t state_q, state_d;
    logic   gcore_q, gcore_d;   // granted core
    logic   gsrc_q,  gsrc_d;    // 1 = data source, 0 = instruction source
    logic   last_q,  last_d;    // core served last

    logic [1:0] req;
    logic       win;
    logic       greq;
    logic       wen;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    assign tmo_err = tmo_q;
`endif

    assign bus.iload = {CPUS{bus.ramload}};
    assign bus.dload = {CPUS{bus.ramload}};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ARB;
            gcore_q <= 1'b0;
            gsrc_q  <= 1'b0;
            last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gcore_q <= gcore_d;
            gsrc_q  <= gsrc_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        gcore_d      = gcore_q;
        gsrc_d       = gsrc_q;
        last_d       = last_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        req          = bus.iREN | bus.dREN | bus.dWEN;
        win          = 1'b0;
        greq         = gsrc_q ? (bus.dREN[gcore_q] | bus.dWEN[gcore_q]) : bus.iREN[gcore_q];
        wen          = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        tmo_d        = 1'b0;
`endif
        unique case (state_q)
            ARB: begin
                if (|req) begin
                    // Tie goes to the core that was not served last.
                    win     = (req[0] & req[1]) ? ~last_q : req[1];
                    gcore_d = win;
                    gsrc_d  = bus.dREN[win] | bus.dWEN[win];
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                wen          = greq & gsrc_q & bus.dWEN[gcore_q];
                bus.ramWEN   = wen;
                bus.ramREN   = greq & ~wen;
                bus.ramaddr  = gsrc_q ? bus.daddr[gcore_q] : bus.iaddr[gcore_q];
                bus.ramstore = bus.dstore[gcore_q];
                // A withdrawn request aborts silently; round-robin order is kept.
                if (!greq) begin
                    state_d = ARB;
                end else if (bus.ramstate == ACCESS) begin
                    if (gsrc_q) bus.dwait[gcore_q] = 1'b0;
                    else        bus.iwait[gcore_q] = 1'b0;
                    last_d  = gcore_q;
                    state_d = ARB;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TMO - 1)) begin
                    tmo_d   = 1'b1;
                    last_d  = gcore_q;
                    state_d = ARB;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed vector table plus hand-written reset and timeout sequences for memory_arbiter.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam logic [31:0] IA0 = 32'h100, IA1 = 32'h200, DA0 = 32'h300, DA1 = 32'h400;
    localparam logic [31:0] DS0 = 32'hAAAA5555, DS1 = 32'h12345678;

    logic CLK = 1'b0;
    logic nRST;
`ifdef ARB_TIMEOUT_EN
    logic tmo_err;
`endif

    memory_arbiter_if #(.CPUS(2)) bus();

    memory_arbiter #(.CPUS(2), .TMO(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .tmo_err (tmo_err)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  iren, dren, dwen;
        ramstate_t   rs;
        logic        ren, wen;
        logic [31:0] addr;
        logic [1:0]  iw, dw;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [1:0] iren, dren, dwen, input ramstate_t rs,
                                input logic ren, wen, input logic [31:0] addr,
                                input logic [1:0] iw, dw);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
        v.ren = ren; v.wen = wen; v.addr = addr; v.iw = iw; v.dw = dw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] iren, dren, dwen, input ramstate_t rs);
        bus.iREN = iren; bus.dREN = dren; bus.dWEN = dwen; bus.ramstate = rs;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        drive(2'b00, 2'b00, 2'b00, FREE);
        bus.iaddr  = {IA1, IA0};
        bus.daddr  = {DA1, DA0};
        bus.dstore = {DS1, DS0};
        bus.ramload = 32'h0;

        // Both cores write continuously: C0, C1, C0, C1
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA0, 2'b11, 2'b10));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA1, 2'b11, 2'b01));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA0, 2'b11, 2'b10));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b11, ACCESS, 0, 1, DA1, 2'b11, 2'b01));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        // Single I0 read
        tv.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, IA0, 2'b10, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        // D0 before I0
        tv.push_back(mk(2'b01, 2'b01, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b01, 2'b00, ACCESS, 1, 0, DA0, 2'b11, 2'b10));
        tv.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, IA0, 2'b10, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        // I1 with three BUSY cycles
        tv.push_back(mk(2'b10, 2'b00, 2'b00, BUSY,   0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b10, 2'b00, 2'b00, BUSY,   1, 0, IA1, 2'b11, 2'b11));
        tv.push_back(mk(2'b10, 2'b00, 2'b00, BUSY,   1, 0, IA1, 2'b11, 2'b11));
        tv.push_back(mk(2'b10, 2'b00, 2'b00, BUSY,   1, 0, IA1, 2'b11, 2'b11));
        tv.push_back(mk(2'b10, 2'b00, 2'b00, ACCESS, 1, 0, IA1, 2'b01, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        // D0 withdrawn while BUSY, then a tie must go to core 0
        tv.push_back(mk(2'b00, 2'b01, 2'b00, BUSY,   0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b01, 2'b00, BUSY,   1, 0, DA0, 2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, BUSY,   0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b11, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b11, 2'b00, 2'b00, ACCESS, 1, 0, IA0, 2'b10, 2'b11));
        // Late D0 request does not steal an I0 grant
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, IA0, 2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b01, 2'b00, BUSY,   1, 0, IA0, 2'b11, 2'b11));
        tv.push_back(mk(2'b01, 2'b01, 2'b00, ACCESS, 1, 0, IA0, 2'b10, 2'b11));
        tv.push_back(mk(2'b00, 2'b01, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b01, 2'b00, ACCESS, 1, 0, DA0, 2'b11, 2'b10));
        // D1 with read and write both high: write only
        tv.push_back(mk(2'b00, 2'b10, 2'b10, ACCESS, 0, 0, 0,   2'b11, 2'b11));
        tv.push_back(mk(2'b00, 2'b10, 2'b10, ACCESS, 0, 1, DA1, 2'b11, 2'b01));
        tv.push_back(mk(2'b00, 2'b00, 2'b00, ACCESS, 0, 0, 0,   2'b11, 2'b11));

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_iwait", 32'(bus.iwait), 32'h3);
        chk("rst_dwait", 32'(bus.dwait), 32'h3);
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
`ifdef ARB_TIMEOUT_EN
        chk("rst_tmo", 32'(tmo_err), 32'h0);
`endif
        nRST = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge CLK);
            #1;
            drive(tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].rs);
            bus.ramload = 32'hC0DE_0000 + 32'(i);
            @(negedge CLK);
            chk($sformatf("v%0d_ramREN", i), 32'(bus.ramREN), 32'(tv[i].ren));
            chk($sformatf("v%0d_ramWEN", i), 32'(bus.ramWEN), 32'(tv[i].wen));
            chk($sformatf("v%0d_iwait", i), 32'(bus.iwait), 32'(tv[i].iw));
            chk($sformatf("v%0d_dwait", i), 32'(bus.dwait), 32'(tv[i].dw));
            chk($sformatf("v%0d_iload1", i), bus.iload[1], 32'hC0DE_0000 + 32'(i));
            chk($sformatf("v%0d_dload0", i), bus.dload[0], 32'hC0DE_0000 + 32'(i));
            if (tv[i].ren || tv[i].wen)
                chk($sformatf("v%0d_ramaddr", i), bus.ramaddr, tv[i].addr);
            if (tv[i].wen)
                chk($sformatf("v%0d_ramstore", i), bus.ramstore, (tv[i].addr == DA0) ? DS0 : DS1);
        end

        // Reset asserted mid-GRANT while ACCESS: no wait may drop
        @(posedge CLK); #1;
        drive(2'b01, 2'b00, 2'b00, ACCESS);
        @(posedge CLK); #1;
        chk("mrst_pre_ramREN", 32'(bus.ramREN), 32'h1);
        nRST = 1'b0;
        #1;
        chk("mrst_iwait", 32'(bus.iwait), 32'h3);
        chk("mrst_ramREN", 32'(bus.ramREN), 32'h0);
        @(negedge CLK);
        chk("mrst_iwait_neg", 32'(bus.iwait), 32'h3);
        drive(2'b00, 2'b00, 2'b00, FREE);
        @(negedge CLK);
        nRST = 1'b1;

`ifdef ARB_TIMEOUT_EN
        // Stuck BUSY: four GRANT cycles, tmo_err pulse, then the other core
        @(posedge CLK); #1;
        drive(2'b11, 2'b00, 2'b00, BUSY);
        @(negedge CLK);
        chk("tmo_arb_ren", 32'(bus.ramREN), 32'h0);
        for (int g = 0; g < 4; g++) begin
            @(negedge CLK);
            chk($sformatf("tmo_g%0d_addr", g), bus.ramaddr, IA0);
            chk($sformatf("tmo_g%0d_err", g), 32'(tmo_err), 32'h0);
        end
        @(negedge CLK);
        chk("tmo_pulse", 32'(tmo_err), 32'h1);
        chk("tmo_iwait", 32'(bus.iwait), 32'h3);
        chk("tmo_ren_off", 32'(bus.ramREN), 32'h0);
        @(negedge CLK);
        chk("tmo_next_addr", bus.ramaddr, IA1);
        chk("tmo_clear", 32'(tmo_err), 32'h0);
        drive(2'b00, 2'b00, 2'b00, FREE);
`endif

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
